ram_fifo: RTL and testbench
===========================

# ram_fifo

Synchronous show-ahead FIFO: write/read pointer control and occupancy logic around a `2**widthad`-entry simple dual-port memory (registered write, combinational read). It fills the memory's write port from a producer and drains its read port to a consumer. It is the standard buffering stage between clocked producers and consumers in the core, one clock domain only.

## Interface
- `width`, 8, data word width in bits
- `widthad`, 4, address width; depth `DEPTH = 2**widthad`
- `almost_full_level`, `2**widthad - 2`, threshold for `almost_full` (present only with `RAM_FIFO_ALMOST_FULL_EN`)

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge
- `rst`  input  1  synchronous reset, active-high
- `data`  input  width  write data
- `wrreq`  input  1  write request
- `rdreq`  input  1  read request (acknowledge of current `q`)
- `q`  output  width  head-of-queue word (show-ahead)
- `empty`  output  1  no valid entries
- `full`  output  1  `DEPTH` entries held
- `usedw`  output  widthad+1  number of entries held, 0..DEPTH
- `overflow`  output  1  one-cycle pulse: write rejected while full
- `underflow`  output  1  one-cycle pulse: read rejected while empty
- `almost_full`  output  1  `usedw >= almost_full_level` (only with `RAM_FIFO_ALMOST_FULL_EN`)

## Operation
- State: `wr_ptr`, `rd_ptr` (widthad bits each, wrap modulo DEPTH), `usedw` counter (widthad+1 bits).
- Write accepted: `wrreq && !full`. Memory write at `wr_ptr`, `wr_ptr <= wr_ptr + 1`.
- Read accepted: `rdreq && !empty`. `rd_ptr <= rd_ptr + 1`.
- `usedw` next: +1 on write-only accepted, -1 on read-only accepted, unchanged if both or neither accepted.
- `empty = (usedw == 0)`, `full = usedw[widthad]` (i.e. `usedw == DEPTH`); both derived from the registered counter.
- `q = mem[rd_ptr]` combinational; value is don't-care while `empty`.
- Full, `wrreq && rdreq`: read accepted, write rejected, `overflow` pulses; `usedw` becomes DEPTH-1.
- Empty, `wrreq && rdreq`: write accepted, read rejected, `underflow` pulses; `usedw` becomes 1.
- Rejected operations change neither pointers nor memory.
- `overflow <= wrreq && full`; `underflow <= rdreq && empty` (registered, asserted the cycle after the offending request).
- Pointer wrap: DEPTH-1 -> 0 with no special handling; `usedw` never wraps.

## Timing
- Reset (`rst` high at a rising edge): `wr_ptr = rd_ptr = 0`, `usedw = 0`, `empty = 1`, `full = 0`, `overflow = underflow = 0`, `almost_full = 0`. Memory contents not cleared. Reset has priority over `wrreq`/`rdreq` in the same cycle; reset mid-stream discards all entries.
- Write-to-read latency: word written at edge N is on `q` with `empty = 0` after edge N (usable in cycle N+1).
- Read acknowledge: `rdreq` with `!empty` at edge N; next word (or `empty = 1`) on `q` after edge N.
- Sustained throughput: one write and one read per cycle when neither full nor empty.
- `full`, `empty`, `usedw`, `almost_full` change only at clock edges.

## Configuration
- `RAM_FIFO_ALMOST_FULL_EN` defined: `almost_full_level` parameter and `almost_full` port exist; `almost_full` is the registered-counter compare `usedw >= almost_full_level`, 0 in reset.
- Undefined: neither parameter nor port exists; all other behaviour identical.

## Test plan
- Reset then idle, width=8, widthad=2 -> `empty=1`, `full=0`, `usedw=0`, no pulses.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles -> `usedw` 1,2,3,4; `full=1` after 4th edge; `q=0x11` from cycle after first write.
- Full, then `wrreq` with 0x55 -> `overflow` pulse one cycle, `usedw=4`; subsequent reads return 0x11,0x22,0x33,0x44 then `empty=1` (0x55 never appears).
- Empty, `rdreq` -> `underflow` pulse; `wrreq`+`rdreq` same cycle with 0x66 -> `usedw=1`, `q=0x66`, `underflow` pulse.
- Half-full, simultaneous read/write for 10 cycles with incrementing data -> `usedw` constant, output order strictly FIFO across pointer wrap.
- With 3 entries, assert `rst` together with `wrreq` -> `usedw=0`, `empty=1` next cycle; with `RAM_FIFO_ALMOST_FULL_EN`, `almost_full_level=2`: `almost_full` rises after 2nd write, falls after read to 1 entry.

Source files
------------

// File: rtl/ram_fifo.sv
// Single-clock show-ahead FIFO around a 2**widthad-entry memory (registered write, comb read).
// Optional almost_full flag/parameter enabled by defining RAM_FIFO_ALMOST_FULL_EN.
module ram_fifo #(
  parameter int unsigned width   = 8,
  parameter int unsigned widthad = 4
`ifdef RAM_FIFO_ALMOST_FULL_EN
  ,
  parameter int unsigned almost_full_level = 2**widthad - 2
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [width-1:0]   data,
  input  logic               wrreq,
  input  logic               rdreq,
  output logic [width-1:0]   q,
  output logic               empty,
  output logic               full,
  output logic [widthad:0]   usedw,
  output logic               overflow,
  output logic               underflow
`ifdef RAM_FIFO_ALMOST_FULL_EN
  ,
  output logic               almost_full
`endif
);

  localparam int unsigned Depth = 2**widthad;
  localparam logic [widthad-1:0] PtrOne  = widthad'(1);
  localparam logic [widthad:0]   UsedOne = (widthad + 1)'(1);

  logic [width-1:0]   mem_q [Depth];
  logic [widthad-1:0] wr_ptr_q, wr_ptr_d;
  logic [widthad-1:0] rd_ptr_q, rd_ptr_d;
  logic [widthad:0]   usedw_q, usedw_d;
  logic               overflow_q, underflow_q;
  logic               wr_en, rd_en;

  assign empty = (usedw_q == '0);
  assign full  = usedw_q[widthad];

  always_comb begin
    wr_en    = wrreq && !full;
    rd_en    = rdreq && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrOne : rd_ptr_q;
    usedw_d  = usedw_q;
    if (wr_en && !rd_en) begin
      usedw_d = usedw_q + UsedOne;
    end else if (rd_en && !wr_en) begin
      usedw_d = usedw_q - UsedOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      overflow_q  <= wrreq && full;
      underflow_q <= rdreq && empty;
    end
  end

  // Memory is deliberately not reset; a reset only discards entries via the pointers.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  assign q         = mem_q[rd_ptr_q];
  assign usedw     = usedw_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef RAM_FIFO_ALMOST_FULL_EN
  localparam logic [widthad:0] AfLevel = almost_full_level[widthad:0];
  assign almost_full = (usedw_q >= AfLevel);
`endif

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo (width=8, widthad=2): queue-based reference model
// compared every cycle, plus hand-computed literal checks.
module tb_ram_fifo;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;
  logic [7:0] q;
  logic       empty, full, overflow, underflow;
  logic [2:0] usedw;
`ifdef RAM_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int n_total = 0;
  int n_pass  = 0;

  ram_fifo #(
    .width  (8),
    .widthad(2)
`ifdef RAM_FIFO_ALMOST_FULL_EN
    ,
    .almost_full_level(2)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .wrreq    (wrreq),
    .rdreq    (rdreq),
    .q        (q),
    .empty    (empty),
    .full     (full),
    .usedw    (usedw),
    .overflow (overflow),
    .underflow(underflow)
`ifdef RAM_FIFO_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain queue of accepted words plus expected pulse flags.
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      automatic bit was_full  = (mq.size() == Depth);
      automatic bit was_empty = (mq.size() == 0);
      m_ovf = wrreq && was_full;
      m_unf = rdreq && was_empty;
      if (rdreq && !was_empty) void'(mq.pop_front());
      if (wrreq && !was_full) mq.push_back(data);
    end
    m_valid = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("m_usedw", 32'(usedw), 32'(mq.size()));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_full", 32'(full), 32'(mq.size() == Depth));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
      if (mq.size() != 0) chk("m_q", 32'(q), 32'(mq[0]));
`ifdef RAM_FIFO_ALMOST_FULL_EN
      chk("m_almost_full", 32'(almost_full), 32'(mq.size() >= 2));
`endif
    end
  end

  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst   = r;
    wrreq = w;
    rdreq = rd;
    data  = d;
    @(negedge clk);
  endtask

  logic [7:0] exp_rd [4];

  initial begin
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_usedw", 32'(usedw), 32'd0);
    chk("rst_pulses", 32'({overflow, underflow}), 32'd0);

    step(0, 1, 0, 8'h11);
    chk("first_q", 32'(q), 32'h11);
    chk("first_usedw", 32'(usedw), 32'd1);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    chk("three_usedw", 32'(usedw), 32'd3);
    step(0, 1, 0, 8'h44);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_usedw", 32'(usedw), 32'd4);

    step(0, 1, 0, 8'h55);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_usedw", 32'(usedw), 32'd4);
    step(0, 0, 0, 8'h00);
    chk("ovf_clear", 32'(overflow), 32'd0);

    for (int i = 0; i < 4; i++) begin
      chk("drain_q", 32'(q), 32'(exp_rd[i]));
      step(0, 0, 1, 8'h00);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    step(0, 0, 1, 8'h00);
    chk("unf_pulse", 32'(underflow), 32'd1);
    step(0, 1, 1, 8'h66);
    chk("empty_rw_usedw", 32'(usedw), 32'd1);
    chk("empty_rw_q", 32'(q), 32'h66);
    chk("empty_rw_unf", 32'(underflow), 32'd1);

    // Two entries held, then ten simultaneous read/writes across the pointer wrap.
    step(0, 1, 0, 8'h70);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 8'h80 + 8'(i));
      chk("stream_usedw", 32'(usedw), 32'd2);
    end
    chk("stream_q", 32'(q), 32'h88);

    step(0, 1, 0, 8'h90);
    step(0, 1, 0, 8'h91);
    step(0, 1, 1, 8'hA0);
    chk("full_rw_usedw", 32'(usedw), 32'd3);
    chk("full_rw_ovf", 32'(overflow), 32'd1);
    chk("full_rw_q", 32'(q), 32'h89);

    step(1, 1, 0, 8'hB0);
    chk("midrst_usedw", 32'(usedw), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);

    step(0, 1, 0, 8'hC1);
`ifdef RAM_FIFO_ALMOST_FULL_EN
    chk("af_one", 32'(almost_full), 32'd0);
`endif
    step(0, 1, 0, 8'hC2);
`ifdef RAM_FIFO_ALMOST_FULL_EN
    chk("af_rise", 32'(almost_full), 32'd1);
`endif
    chk("after_rst_q", 32'(q), 32'hC1);
    step(0, 0, 1, 8'h00);
`ifdef RAM_FIFO_ALMOST_FULL_EN
    chk("af_fall", 32'(almost_full), 32'd0);
`endif
    chk("after_rst_q2", 32'(q), 32'hC2);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
